// File: rtl/xalu_seq_ctrl.sv
// rtl/xalu_seq_ctrl.sv - multiply/divide sequencer owning HI/LO for the execute stage
//
// Purpose: accepts one mult/multu/div/divu/mul/mthi/mtlo at a time, runs a
// fixed-latency multiply or a restoring divide, commits HI/LO or hands the mul
// result to the GPR writeback port, and stalls the pipeline while working.
//
// Ports:
//   Clk, Clr                  clock (rising edge), async active-high reset
//   issue_valid/op/a/b/rd     issue request, ignored unless idle
//   cancel                    exception flush, aborts in-flight work
//   busy                      stall request (state != IDLE)
//   hi, lo                    architectural HI/LO
//   wb_valid/rd/data, wb_ready   mul result writeback handshake
module xalu_seq_ctrl #(
    parameter int MUL_LAT    = 3,
    parameter int DIV_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready
);

    localparam int CW = ($clog2(MUL_LAT) > $clog2(DIV_CYCLES)) ? $clog2(MUL_LAT) : $clog2(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_WB
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_busy;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          r_wb_valid;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_data;

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_a;        // multiplicand, or original dividend for divide-by-zero HI
    logic [31:0]   r_b;        // multiplier, or divisor magnitude
    logic          r_signed;
    logic          r_is_mul;
    logic [4:0]    r_rd;
    logic [63:0]   r_rq;       // remainder:quotient shift register
    logic          r_q_neg;
    logic          r_r_neg;
    logic          r_dz;

    logic          w_accept;
    logic          w_sa;
    logic          w_sb;
    logic [63:0]   w_ax;
    logic [63:0]   w_bx;
    logic [63:0]   w_prod;
    logic [63:0]   w_shift;
    logic [32:0]   w_sub;
    logic [63:0]   w_div_step;

    assign w_accept = issue_valid && (r_state == S_IDLE) && !cancel;

    assign w_sa = (issue_op == OP_DIV) && issue_a[31];
    assign w_sb = (issue_op == OP_DIV) && issue_b[31];

    // Extending to 64 bits first lets one truncated product serve both signednesses.
    assign w_ax   = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_bx   = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_ax * w_bx;

    // Partial remainder stays below the divisor magnitude (<= 2^31), so the
    // bit shifted out of r_rq[63] is always zero.
    assign w_shift    = {r_rq[62:0], 1'b0};
    assign w_sub      = {1'b0, w_shift[63:32]} - {1'b0, r_b};
    assign w_div_step = w_sub[32] ? w_shift : {w_sub[31:0], w_shift[31:1], 1'b1};

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (issue_op)
                        OP_MULT, OP_MULTU, OP_MUL: w_next = S_MUL;
                        OP_DIV, OP_DIVU:           w_next = S_DIV;
                        default:                   w_next = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = r_is_mul ? S_WB : S_IDLE;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: w_next = S_IDLE;
            S_WB: begin
                if (cancel || wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_busy     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_is_mul   <= 1'b0;
            r_rd       <= '0;
            r_rq       <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_busy     <= (w_next != S_IDLE);
            r_wb_valid <= (w_next == S_WB);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (issue_op)
                            OP_MTHI: r_hi <= issue_a;
                            OP_MTLO: r_lo <= issue_a;
                            OP_MULT, OP_MULTU, OP_MUL: begin
                                r_a      <= issue_a;
                                r_b      <= issue_b;
                                r_signed <= (issue_op != OP_MULTU);
                                r_is_mul <= (issue_op == OP_MUL);
                                r_rd     <= issue_rd;
                                r_cnt    <= CW'(MUL_LAT - 1);
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a     <= issue_a;
                                r_b     <= w_sb ? (~issue_b + 32'd1) : issue_b;
                                r_rq    <= {32'd0, (w_sa ? (~issue_a + 32'd1) : issue_a)};
                                r_q_neg <= w_sa ^ w_sb;
                                r_r_neg <= w_sa;
                                r_dz    <= (issue_b == 32'd0);
                                r_cnt   <= CW'(DIV_CYCLES - 1);
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (!cancel) begin
                        if (r_cnt == '0) begin
                            if (r_is_mul) begin
                                r_wb_data <= w_prod[31:0];
                                r_wb_rd   <= r_rd;
                            end else begin
                                r_hi <= w_prod[63:32];
                                r_lo <= w_prod[31:0];
                            end
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_DIV: begin
                    if (!cancel) begin
                        r_rq <= w_div_step;
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        if (r_dz) begin
                            r_hi <= r_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            // 0x80000000 / -1 negates 0x80000000 back onto itself, as required.
                            r_hi <= r_r_neg ? (~r_rq[63:32] + 32'd1) : r_rq[63:32];
                            r_lo <= r_q_neg ? (~r_rq[31:0] + 32'd1) : r_rq[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_xalu_seq_ctrl.sv
// tb/tb_xalu_seq_ctrl.sv - directed self-checking bench for xalu_seq_ctrl
module tb_xalu_seq_ctrl;

    logic        Clk;
    logic        Clr;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;

    int total;
    int bad;

    xalu_seq_ctrl #(.MUL_LAT(3), .DIV_CYCLES(32)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .issue_valid(issue_valid),
        .issue_op   (issue_op),
        .issue_a    (issue_a),
        .issue_b    (issue_b),
        .issue_rd   (issue_rd),
        .cancel     (cancel),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one op for a single edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge Clk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        @(posedge Clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Counts cycles with busy high, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b, 5'd0);
        wait_idle(n);
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int n;
        total       = 0;
        bad         = 0;
        Clr         = 1'b1;
        issue_valid = 1'b0;
        issue_op    = 3'd0;
        issue_a     = '0;
        issue_b     = '0;
        issue_rd    = '0;
        cancel      = 1'b0;
        wb_ready    = 1'b0;

        #23;
        Clr = 1'b0;
        @(negedge Clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_wbv", 64'(wb_valid), 64'd0);
        chk("rst_wbrd", 64'(wb_rd), 64'd0);
        chk("rst_wbdata", 64'(wb_data), 64'd0);

        // Multiplies
        run_op("mult", 3'b000, 32'hFFFFFFFF, 32'h00000002, 3, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'h00000002, 3, 32'h00000001, 32'hFFFFFFFE);

        // Divides
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'b011, 32'd100, 32'd7, 33, 32'h00000002, 32'h0000000E);
        run_op("divu_dz", 3'b011, 32'h12345678, 32'h0, 33, 32'h12345678, 32'hFFFFFFFF);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);

        // mthi, no busy
        issue(3'b100, 32'hAAAA0000, 32'h0, 5'd0);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_hi", 64'(hi), 64'hAAAA0000);

        // cancel together with issue in IDLE: nothing accepted
        cancel = 1'b1;
        issue(3'b100, 32'h11111111, 32'h0, 5'd0);
        cancel = 1'b0;
        chk("cancel_idle_hi", 64'(hi), 64'hAAAA0000);
        chk("cancel_idle_busy", 64'(busy), 64'd0);

        // div cancelled on busy cycle 10
        issue(3'b010, 32'd100, 32'd7, 5'd0);
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        chk("cyc10_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge Clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_hi", 64'(hi), 64'hAAAA0000);
        chk("cancel_lo", 64'(lo), 64'h80000000);
        run_op("post_cancel", 3'b001, 32'd3, 32'd4, 3, 32'h0, 32'd12);

        // mul with writeback backpressure
        issue(3'b110, 32'd7, 32'hFFFFFFFD, 5'd9);
        n = 0;
        while (!wb_valid && n < 100) begin
            n++;
            @(posedge Clk);
            #1;
        end
        chk("mul_lat", 64'(n), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("wb_hold_valid", 64'(wb_valid), 64'd1);
            chk("wb_hold_rd", 64'(wb_rd), 64'd9);
            chk("wb_hold_data", 64'(wb_data), 64'hFFFFFFEB);
            chk("wb_hold_busy", 64'(busy), 64'd1);
            @(posedge Clk);
            #1;
        end
        wb_ready = 1'b1;
        chk("wb_xfer_valid", 64'(wb_valid), 64'd1);
        @(posedge Clk);
        #1;
        wb_ready = 1'b0;
        chk("wb_after_valid", 64'(wb_valid), 64'd0);
        chk("wb_after_busy", 64'(busy), 64'd0);
        chk("mul_hi", 64'(hi), 64'h0);
        chk("mul_lo", 64'(lo), 64'd12);

        // async reset mid-divide
        issue(3'b100, 32'h77, 32'h0, 5'd0);
        issue(3'b011, 32'd1000, 32'd3, 5'd0);
        repeat (5) @(posedge Clk);
        #2;
        Clr = 1'b1;
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_hi", 64'(hi), 64'd0);
        chk("clr_lo", 64'(lo), 64'd0);
        chk("clr_wbrd", 64'(wb_rd), 64'd0);
        chk("clr_wbdata", 64'(wb_data), 64'd0);
        #3;
        Clr = 1'b0;
        issue(3'b101, 32'd5, 32'h0, 5'd0);
        chk("post_clr_lo", 64'(lo), 64'd5);
        chk("post_clr_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
